fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the FIFO/LIFO DUT between NREQ requesters.
- Sits on the write-clock side. Drives Wren and Datain of the DUT and honours its Full flag.
- Each grant is a burst of up to MAXBURST words. Ownership then rotates so no requester can starve another.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DAT_WIDTH, 32, data word width; matches the DUT data width.
- MAXBURST, 4, maximum words accepted per grant (1..16).

Ports:
- Clk  input  1  write-side clock; drive with the DUT Wrclk.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  NREQ  per-requester request; hold high while a word is valid.
- Reqdata  input  NREQ*DAT_WIDTH  requester data; slice i is bits [i*DAT_WIDTH +: DAT_WIDTH].
- Full  input  1  DUT Full flag.
- Ack  output  NREQ  one-hot; requester i's word is consumed this cycle.
- Wren  output  1  DUT write enable.
- Datain  output  DAT_WIDTH  DUT write data.
- Owner  output  clog2(NREQ)  index of the current or last granted requester.
- Busy  output  1  high in state GRANT.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high (Rst).
- Reset values: state=IDLE, Owner=0, Ptr=0, BurstCnt=0, Ack=0, Wren=0, Datain=0, Busy=0. Asserting Rst mid-burst drops Wren and Ack immediately, because they decode from state. No partial word is ever written.
- State IDLE:
  - Busy=0, Wren=0.
  - If Req!=0, search from Ptr upward modulo NREQ and take the first set bit as Owner. Clear BurstCnt and go to GRANT next cycle.
  - This costs one arbitration cycle per grant, and no word is accepted in IDLE.
- State GRANT:
  - Busy=1.
  - accept = Req[Owner] & ~Full.
  - Wren = accept; Ack = accept << Owner; Datain = Reqdata slice Owner when accept, else 0.
  - All three are combinational, so the write lands on the same edge as the Ack.
- Counting: on accept, BurstCnt increments by 1. Its width is clog2(MAXBURST)+1, so no wrap is possible within a burst.
- Exits from GRANT to IDLE (on exit, Ptr = (Owner+1) mod NREQ and Owner holds its value):
  - Req[Owner]=0 in a cycle: exit, no word written.
  - accept with BurstCnt==MAXBURST-1: the last word is written on that edge, then exit.
- Full stall: Full=1 with Req[Owner]=1 keeps the block in GRANT. Wren=0, Ack=0, no count change. There is no timeout.
- Requesters: Req[i] may change only after an Ack for i, or while i is not the owner. Dropping Req[Owner] ends the grant. Requests from non-owners are ignored until the next IDLE.
- NREQ not a power of two: Ptr wraps from NREQ-1 to 0. Owner never exceeds NREQ-1.
- Simultaneous events:
  - Full rising on the same edge as the last-burst accept: the word is still written, since Full was 0 in that cycle.
  - Req of a new requester arriving during the exit cycle: seen in IDLE on the next cycle.
- Invariants for the bench to assert:
  - Wren is never high while Full is high.
  - Ack is 0 or one-hot.
  - Wren equals the OR-reduction of Ack.

Test Plan:
- Reset: Rst pulsed mid-burst with Req=4'b0001 and 2 of 4 words written -> Wren=0, Ack=0, Busy=0 and Owner=0 in the same cycle. After release, a new grant takes 1 IDLE cycle.
- Single burst: Req=4'b0100 held, Full=0, data 0xA0..0xA5 -> Owner=2. Exactly 4 Acks and writes (0xA0..0xA3) on consecutive cycles, then 1 IDLE cycle, then a new grant to 2 writes 0xA4 and 0xA5.
- Round-robin: Req=4'b1111 held -> grant order 0,1,2,3,0, each 4 words and each preceded by 1 IDLE cycle. Total 20 words over 25 cycles.
- Full stall: Owner=1, Full=1 for 3 cycles after the 2nd word -> Wren=0 and Ack=0 for those 3 cycles, Busy=1, BurstCnt stays 2. The burst then completes with 2 more words.
- Early drop: Owner=3, Req[3] drops after 1 word -> GRANT exits, Ptr=0. Next grant goes to the lowest-index pending requester at or after 0.
- FIFO integration: arbiter wired to the DUT (MODE=0, DEPTH=64), Req=4'b0011, no reads -> exactly 64 words are written, then Wren stays 0 while Full=1. Read-back order matches the Ack order.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
// One arbitration cycle in IDLE, then up to MAXBURST words from the owner in GRANT.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DAT_WIDTH = 32,
  parameter int MAXBURST  = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*DAT_WIDTH-1:0] Reqdata,
  input  logic                      Full,
  output logic [NREQ-1:0]           Ack,
  output logic                      Wren,
  output logic [DAT_WIDTH-1:0]      Datain,
  output logic [$clog2(NREQ)-1:0]   Owner,
  output logic                      Busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [OW-1:0]   next_ptr;
  logic [OW-1:0]   pick;
  logic [OW-1:0]   idx;
  logic            found;
  logic            accept;

  // Rotating priority search starting at ptr_q, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = OW'((int'(ptr_q) + k) % NREQ);
      if (!found && Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    accept   = (state_q == GRANT) && Req[owner_q] && !Full;
    Wren     = accept;
    Ack      = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    Datain   = accept ? Reqdata[int'(owner_q)*DAT_WIDTH +: DAT_WIDTH] : '0;
    Busy     = (state_q == GRANT);
    Owner    = owner_q;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!Req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          // Last word of the burst is written on this edge, then ownership rotates.
          if (burst_cnt_q == CW'(MAXBURST - 1)) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
